// File: rtl/pwm_dac_out.sv
// pwm_dac_out: 8-bit PWM DAC driver with a two-state (IDLE/RUN) controller.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   en         - level-sensitive run request, sampled only at period end while running
//   wave[7:0]  - unsigned sample; latched into the duty register on entry and at each wrap
//   pwm_out    - running && (period_cnt < duty), registered
//   sample_ack - one-cycle pulse in the cycle after wave was latched
//   period_cnt - PWM step counter, 0..254
//   running    - high while in RUN
//
// Parameter DIV (>= 1): clock cycles per PWM step. A full period is 255*DIV clocks.

module pwm_dac_out #(
  parameter int unsigned DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] wave,
  output logic       pwm_out,
  output logic       sample_ack,
  output logic [7:0] period_cnt,
  output logic       running
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] LAST_STEP = CW'(254);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] duty_q, duty_d;
  logic          ack_q, ack_d;
  logic          pwm_q, pwm_d;
  logic          running_q, running_d;
  logic          tick;

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    ack_d   = 1'b0;
    tick    = (presc_q == PRESC_MAX);

    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        cnt_d   = '0;
        if (en) begin
          state_d = RUN;
          duty_d  = wave;
          ack_d   = 1'b1;
        end
      end
      RUN: begin
        if (tick) begin
          presc_d = '0;
          if (cnt_q == LAST_STEP) begin
            // Period end: the only point where en is honoured.
            cnt_d = '0;
            if (en) begin
              duty_d = wave;
              ack_d  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    endcase

    // Decode from next-state values so the registered pwm_out lines up with
    // the registered counter and duty in the same cycle.
    running_d = (state_d == RUN);
    pwm_d     = running_d && (cnt_d < duty_d);
  end

  // State register; reset wins over every other event on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      cnt_q     <= '0;
      duty_q    <= '0;
      ack_q     <= 1'b0;
      pwm_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      duty_q    <= duty_d;
      ack_q     <= ack_d;
      pwm_q     <= pwm_d;
      running_q <= running_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign sample_ack = ack_q;
  assign period_cnt = cnt_q;
  assign running    = running_q;

endmodule
